restoring_divider_p: RTL and testbench
======================================

Name: restoring_divider_p

Overview:
- Parametrised, multi-cycle restoring divider. Divides a DIVIDEND_W-bit dividend by a DIVISOR_W-bit divisor and produces one quotient bit per clock.
- Successor to the fixed 32/16 divider. Adds parametrised widths, divide-by-zero detection, start-while-busy protection, a correct wide-remainder compare and an optional signed mode.
- Sits beside the ALU as a shared long-latency unit, driven by a start/ready handshake.

Parameters:
- DIVIDEND_W, 32, dividend and quotient width; must be at least 2.
- DIVISOR_W, 16, divisor and remainder width; must be at least 1 and no greater than DIVIDEND_W.
- Derived localparam CNT_W = $clog2(DIVIDEND_W), the iteration counter width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- clr  input  1  synchronous, active-high reset.
- start  input  1  request a new division; sampled only when busy=0.
- a  input  DIVIDEND_W  dividend.
- b  input  DIVISOR_W  divisor.
- q  output  DIVIDEND_W  quotient (internal quotient/shift register).
- r  output  DIVISOR_W  remainder.
- ready  output  1  q and r are valid.
- busy  output  1  division in progress.
- count  output  CNT_W  iterations completed in the current division.
- dbz  output  1  last accepted division had b==0.

Behaviour:
- Reset: clr=1 at an edge clears busy, ready, dbz, count, q, r and all internal state to 0. clr has priority over everything, including mid-division; the aborted result is lost.
- Accept: at an edge with clr=0, start=1 and busy=0:
  - Latch b into the divisor register; load q with a; clear r and count.
  - Set ready=0 and dbz=0.
  - If b!=0, set busy=1.
  - If b==0: busy stays 0; ready=1 and dbz=1 at this same edge; q=all ones; r=a[DIVISOR_W-1:0]. No iterations run.
- start while busy=1 is ignored; the in-flight division is unaffected.
- Iteration, each edge while busy=1:
  - Form s = {r, q[DIVIDEND_W-1]}, DIVISOR_W+1 bits.
  - If s >= {1'b0, breg} (unsigned): r <= s - breg (always fits in DIVISOR_W bits), and shift q left inserting 1.
  - Otherwise: r <= s[DIVISOR_W-1:0], and shift q left inserting 0.
  - The compare uses the full DIVISOR_W+1 bits, so a set remainder MSB is handled correctly.
  - count increments by 1.
- Completion: on the iteration edge where count==DIVIDEND_W-1, set busy=0 and ready=1; count wraps to 0.
  - Unsigned latency is exactly DIVIDEND_W edges after the accept edge.
- Hold: after completion, q, r, ready and dbz hold until the next accepted start or clr. q and r change every iteration and are only meaningful when ready=1.
- busy and ready are never both 1.

Optional Feature:
- Macro DIVIDER_SIGNED_EN.
- When defined:
  - a and b are two's complement. At accept, the magnitudes |a| and |b| are loaded, and the result signs are latched: qneg = a_msb XOR b_msb, rneg = a_msb.
  - The iteration is unchanged.
  - After the last iteration there is one extra fix-up edge, during which busy stays 1. At that edge q is negated if qneg, r is negated if rneg, then busy=0 and ready=1. Latency is DIVIDEND_W+1.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative dividend / -1: q wraps to the most-negative value, r=0, no flag.
  - Divide by zero behaves as in unsigned mode (q=all ones, r=a low bits, dbz=1).
- When undefined: purely unsigned; no sign registers or fix-up state are synthesised.

Test Plan:
- Default parameters, a=100, b=7, start pulsed for 1 cycle -> busy for 32 cycles; ready=1 on edge 32 after accept; q=14, r=2, dbz=0.
- a=0xFFFFFFFF, b=0x8001 (remainder MSB path) -> q=0x0001FFFC, r=0x0003. a=0xFFFFFFFF, b=0xFFFF -> q=0x00010001, r=0.
- b=0, a=0x12345678 -> ready=1 and dbz=1 on the accept edge, busy never 1, q=0xFFFFFFFF, r=0x5678.
- Start a=1000, b=3; assert start with a=5, b=1 at count=10 -> ignored; result q=333, r=1. Assert clr at count=20 -> next edge busy=0, ready=0, q=0, r=0.
- DIVIDEND_W=8, DIVISOR_W=4, a=200, b=13 -> ready after 8 edges; q=15, r=5, count back to 0.
- With DIVIDER_SIGNED_EN: a=-100, b=7 -> ready after 33 edges; q=0xFFFFFFF2, r=0xFFFE. a=100, b=-7 -> q=0xFFFFFFF2, r=2.

Source files
------------

// File: rtl/restoring_divider_p.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/ready handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (adds one sign fix-up cycle).
module restoring_divider_p #(
    parameter int unsigned DIVIDEND_W = 32,
    parameter int unsigned DIVISOR_W  = 16
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          start,
    input  logic [DIVIDEND_W-1:0]         a,
    input  logic [DIVISOR_W-1:0]          b,
    output logic [DIVIDEND_W-1:0]         q,
    output logic [DIVISOR_W-1:0]          r,
    output logic                          ready,
    output logic                          busy,
    output logic [$clog2(DIVIDEND_W)-1:0] count,
    output logic                          dbz
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
    localparam int unsigned REM_W = DIVISOR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

`ifdef DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;
`else
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;
`endif

    state_t                  state_q, state_n;
    logic [DIVIDEND_W-1:0]   q_q, q_n;
    logic [DIVISOR_W-1:0]    r_q, r_n;
    logic [DIVISOR_W-1:0]    breg_q, breg_n;
    logic [CNT_W-1:0]        count_q, count_n;
    logic                    busy_q, busy_n;
    logic                    ready_q, ready_n;
    logic                    dbz_q, dbz_n;

    logic [DIVIDEND_W-1:0]   a_mag;
    logic [DIVISOR_W-1:0]    b_mag;
    logic [REM_W-1:0]        rem_shift;
    logic [REM_W-1:0]        rem_diff;
    logic                    rem_ge;

`ifdef DIVIDER_SIGNED_EN
    logic                    qneg_q, qneg_n;
    logic                    rneg_q, rneg_n;

    // Operand magnitudes; the most-negative divisor maps to its own unsigned magnitude
    assign a_mag = a[DIVIDEND_W-1] ? (~a + DIVIDEND_W'(1)) : a;
    assign b_mag = b[DIVISOR_W-1]  ? (~b + DIVISOR_W'(1))  : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // Trial subtract on the full DIVISOR_W+1 bits so a set remainder MSB compares correctly
    assign rem_shift = {r_q, q_q[DIVIDEND_W-1]};
    assign rem_diff  = rem_shift - {1'b0, breg_q};
    assign rem_ge    = (rem_shift >= {1'b0, breg_q});

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            breg_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            q_q     <= q_n;
            r_q     <= r_n;
            breg_q  <= breg_n;
            count_q <= count_n;
            busy_q  <= busy_n;
            ready_q <= ready_n;
            dbz_q   <= dbz_n;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= qneg_n;
            rneg_q  <= rneg_n;
`endif
        end
    end

    always_comb begin
        state_n = state_q;
        q_n     = q_q;
        r_n     = r_q;
        breg_n  = breg_q;
        count_n = count_q;
        busy_n  = busy_q;
        ready_n = ready_q;
        dbz_n   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        qneg_n  = qneg_q;
        rneg_n  = rneg_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ready_n = 1'b0;
                    dbz_n   = 1'b0;
                    count_n = '0;
                    r_n     = '0;
                    if (b == '0) begin
                        // Divide by zero resolves on the accept edge without iterating
                        breg_n  = '0;
                        q_n     = '1;
                        r_n     = a[DIVISOR_W-1:0];
                        ready_n = 1'b1;
                        dbz_n   = 1'b1;
                    end else begin
                        breg_n  = b_mag;
                        q_n     = a_mag;
                        busy_n  = 1'b1;
                        state_n = S_RUN;
`ifdef DIVIDER_SIGNED_EN
                        qneg_n  = a[DIVIDEND_W-1] ^ b[DIVISOR_W-1];
                        rneg_n  = a[DIVIDEND_W-1];
`endif
                    end
                end
            end

            S_RUN: begin
                q_n     = {q_q[DIVIDEND_W-2:0], rem_ge};
                r_n     = rem_ge ? rem_diff[DIVISOR_W-1:0] : rem_shift[DIVISOR_W-1:0];
                count_n = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    count_n = '0;
`ifdef DIVIDER_SIGNED_EN
                    state_n = S_FIX;
`else
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                    state_n = S_IDLE;
`endif
                end
            end

`ifdef DIVIDER_SIGNED_EN
            S_FIX: begin
                q_n     = qneg_q ? (~q_q + DIVIDEND_W'(1)) : q_q;
                r_n     = rneg_q ? (~r_q + DIVISOR_W'(1))  : r_q;
                busy_n  = 1'b0;
                ready_n = 1'b1;
                state_n = S_IDLE;
            end
`endif

            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign q     = q_q;
    assign r     = r_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign dbz   = dbz_q;

endmodule

// File: tb/tb_restoring_divider_p.sv
// Randomized self-checking bench for restoring_divider_p (32/16 and 8/4 instances)
// against an arithmetic reference model; honours DIVIDER_SIGNED_EN.
module tb_restoring_divider_p;

`ifdef DIVIDER_SIGNED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk;
    logic        clr;
    logic        start32, start8;
    logic [31:0] a32, q32;
    logic [15:0] b32, r32;
    logic [4:0]  count32;
    logic        ready32, busy32, dbz32;
    logic [7:0]  a8, q8;
    logic [3:0]  b8, r8;
    logic [2:0]  count8;
    logic        ready8, busy8, dbz8;

    int checks = 0;
    int errors = 0;
    int excl_viol = 0;

    restoring_divider_p #(.DIVIDEND_W(32), .DIVISOR_W(16)) dut32 (
        .clk(clk), .clr(clr), .start(start32), .a(a32), .b(b32),
        .q(q32), .r(r32), .ready(ready32), .busy(busy32), .count(count32), .dbz(dbz32)
    );

    restoring_divider_p #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .a(a8), .b(b8),
        .q(q8), .r(r8), .ready(ready8), .busy(busy8), .count(count8), .dbz(dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((busy32 && ready32) || (busy8 && ready8)) excl_viol++;
    end

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Quotient/remainder from plain integer arithmetic at the given widths
    function automatic void ref_div(input longint unsigned av, input longint unsigned bv,
                                    input int aw, input int bw,
                                    output longint unsigned eq, output longint unsigned er);
        longint sa, sb, qq, rr;
        longint unsigned amask, bmask;
        amask = (64'd1 << aw) - 64'd1;
        bmask = (64'd1 << bw) - 64'd1;
        if (bv == 0) begin
            eq = amask;
            er = av & bmask;
            return;
        end
        sa = longint'(av);
        sb = longint'(bv);
`ifdef DIVIDER_SIGNED_EN
        if (((av >> (aw - 1)) & 64'd1) != 0) sa = sa - longint'(64'd1 << aw);
        if (((bv >> (bw - 1)) & 64'd1) != 0) sb = sb - longint'(64'd1 << bw);
`endif
        qq = sa / sb;
        rr = sa % sb;
        eq = longint'(qq) & amask;
        er = longint'(rr) & bmask;
    endfunction

    function automatic logic get_ready(input bit sm); return sm ? ready8 : ready32; endfunction
    function automatic logic get_busy (input bit sm); return sm ? busy8  : busy32;  endfunction
    function automatic logic get_dbz  (input bit sm); return sm ? dbz8   : dbz32;   endfunction
    function automatic longint unsigned get_q(input bit sm); return sm ? 64'(q8) : 64'(q32); endfunction
    function automatic longint unsigned get_r(input bit sm); return sm ? 64'(r8) : 64'(r32); endfunction
    function automatic longint unsigned get_cnt(input bit sm); return sm ? 64'(count8) : 64'(count32); endfunction

    task automatic do_div(input bit sm, input longint unsigned av_in, input longint unsigned bv_in,
                          input string tag);
        longint unsigned av, bv, eq, er;
        int aw, bw, lat;
        aw = sm ? 8 : 32;
        bw = sm ? 4 : 16;
        av = av_in & ((64'd1 << aw) - 64'd1);
        bv = bv_in & ((64'd1 << bw) - 64'd1);
        ref_div(av, bv, aw, bw, eq, er);
        if (sm) begin a8 = 8'(av); b8 = 4'(bv); start8 = 1'b1; end
        else begin a32 = 32'(av); b32 = 16'(bv); start32 = 1'b1; end
        @(posedge clk); #1;
        start8 = 1'b0;
        start32 = 1'b0;
        if (bv == 0) begin
            check({tag, "_dbz_ready"}, 64'(get_ready(sm)), 1);
            check({tag, "_dbz_busy"}, 64'(get_busy(sm)), 0);
        end else begin
            check({tag, "_busy_after_accept"}, 64'(get_busy(sm)), 1);
            lat = 0;
            while (!get_ready(sm) && lat < 200) begin
                @(posedge clk); #1;
                lat++;
            end
            check({tag, "_latency"}, 64'(lat), 64'(aw + EXTRA));
        end
        check({tag, "_q"}, get_q(sm), eq);
        check({tag, "_r"}, get_r(sm), er);
        check({tag, "_dbz"}, 64'(get_dbz(sm)), (bv == 0) ? 64'd1 : 64'd0);
        check({tag, "_count"}, get_cnt(sm), 0);
    endtask

    initial begin
        longint unsigned eq, er, av, bv;
        int lat;
        bit injected;
        clr = 1'b1; start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 64'(q32), 0);
        check("rst_r", 64'(r32), 0);
        check("rst_ready", 64'(ready32), 0);
        check("rst_busy", 64'(busy32), 0);
        check("rst_dbz", 64'(dbz32), 0);
        check("rst_count", 64'(count32), 0);
        check("rst_q8", 64'(q8), 0);
        clr = 1'b0;
        @(posedge clk); #1;

        do_div(1'b0, 100, 7, "d100_7");
        // Hold after completion
        repeat (3) @(posedge clk);
        #1;
        check("hold_ready", 64'(ready32), 1);
        check("hold_q", 64'(q32), eq_hold(100, 7));
        do_div(1'b0, 64'hFFFF_FFFF, 64'h8001, "rem_msb");
        do_div(1'b0, 64'hFFFF_FFFF, 64'hFFFF, "max_max");
        do_div(1'b0, 64'h1234_5678, 0, "dbz");
        do_div(1'b1, 200, 13, "w8_200_13");
        do_div(1'b1, 8'h80, 0, "w8_dbz");
`ifdef DIVIDER_SIGNED_EN
        do_div(1'b0, 64'hFFFF_FF9C, 7, "sgn_m100_7");
        do_div(1'b0, 100, 64'hFFF9, "sgn_100_m7");
        do_div(1'b0, 64'h8000_0000, 64'hFFFF, "sgn_minneg_m1");
        do_div(1'b1, 8'h80, 4'hF, "w8_minneg_m1");
`endif

        // Start while busy must be ignored
        ref_div(1000, 3, 32, 16, eq, er);
        a32 = 32'd1000; b32 = 16'd3; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 0;
        injected = 1'b0;
        while (!ready32 && lat < 200) begin
            if (count32 == 5'd10 && !injected) begin
                a32 = 32'd5; b32 = 16'd1; start32 = 1'b1; injected = 1'b1;
            end
            @(posedge clk); #1;
            start32 = 1'b0;
            lat++;
        end
        check("sib_latency", 64'(lat), 64'(32 + EXTRA));
        check("sib_q", 64'(q32), eq);
        check("sib_r", 64'(r32), er);

        // clr mid-division aborts the result
        a32 = 32'd1000; b32 = 16'd3; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 0;
        while (count32 != 5'd20 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("clr_reach_cnt20", 64'(count32), 20);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_busy", 64'(busy32), 0);
        check("clr_ready", 64'(ready32), 0);
        check("clr_q", 64'(q32), 0);
        check("clr_r", 64'(r32), 0);
        check("clr_count", 64'(count32), 0);

        for (int i = 0; i < 40; i++) begin
            av = {32'($urandom), 32'($urandom)};
            case ($urandom_range(0, 7))
                0:       bv = 0;
                1:       bv = 64'($urandom_range(1, 15));
                2:       bv = 64'($urandom) | 64'h8000;
                default: bv = 64'($urandom);
            endcase
            do_div(i[0], av, bv, i[0] ? "rnd8" : "rnd32");
        end

        check("busy_ready_exclusive", 64'(excl_viol), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic longint unsigned eq_hold(input longint unsigned av, input longint unsigned bv);
        longint unsigned eq, er;
        ref_div(av, bv, 32, 16, eq, er);
        return eq;
    endfunction

endmodule
